// File: rtl/mult_hilo_ctrl_pkg.sv
// Shared definitions for the multiply HI/LO control stage.
package mult_hilo_ctrl_pkg;

  localparam int DATA_WIDTH      = 32;
  localparam int PROD_WIDTH      = 2 * DATA_WIDTH;
  localparam int DEFAULT_LATENCY = 4;
  localparam int CNT_WIDTH       = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // Counter preload for a given latency: the final (HI/LO-loading) edge is the
  // one on which the counter is already zero, hence the minus one.
  function automatic logic [CNT_WIDTH-1:0] latency_preload(input int latency);
    return CNT_WIDTH'(latency - 1);
  endfunction

endpackage

// File: rtl/mult_hilo_ctrl_hilo_reg_pair.sv
// Architectural HI/LO register pair: loaded as a whole from a 64-bit product,
// or written individually from a shared data word.
module hilo_reg_pair
  import mult_hilo_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_prod,
  input  logic [PROD_WIDTH-1:0] product,
  input  logic                  we_hi,
  input  logic                  we_lo,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);

  // Product load wins over direct writes; the controller never asserts both.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else if (load_prod) begin
      hi <= product[PROD_WIDTH-1:DATA_WIDTH];
      lo <= product[DATA_WIDTH-1:0];
    end else begin
      if (we_hi) hi <= wdata;
      if (we_lo) lo <= wdata;
    end
  end

endmodule

// File: rtl/mult_hilo_ctrl_mult.sv
// Combinational 32x32 -> 64 multiplier arrays, signed and unsigned flavours.
// Their inputs come from held operand latches, so they are multi-cycle paths.
module MULT32
  import mult_hilo_ctrl_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [PROD_WIDTH-1:0] p
);

  logic signed [PROD_WIDTH-1:0] a_ext;
  logic signed [PROD_WIDTH-1:0] b_ext;

  // Sign-extend to full product width; the low 64 bits of the wide product
  // are then the exact two's-complement result.
  assign a_ext = {{DATA_WIDTH{a[DATA_WIDTH-1]}}, a};
  assign b_ext = {{DATA_WIDTH{b[DATA_WIDTH-1]}}, b};
  assign p     = a_ext * b_ext;

endmodule

module MULT32_U
  import mult_hilo_ctrl_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [PROD_WIDTH-1:0] p
);

  logic [PROD_WIDTH-1:0] a_ext;
  logic [PROD_WIDTH-1:0] b_ext;

  // Zero-extend so the multiply is carried out at full product width.
  assign a_ext = {{DATA_WIDTH{1'b0}}, a};
  assign b_ext = {{DATA_WIDTH{1'b0}}, b};
  assign p     = a_ext * b_ext;

endmodule

// File: rtl/mult_hilo_ctrl.sv
// Multiply control stage: latches operands on START, holds them for LATENCY
// cycles while the combinational multipliers settle, then captures the
// product into HI/LO. Also handles MTHI/MTLO and reports BUSY for stalls.
module mult_hilo_ctrl
  import mult_hilo_ctrl_pkg::*;
#(
  parameter int LATENCY = DEFAULT_LATENCY
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic                  SIGNED_OP,
  input  logic [DATA_WIDTH-1:0] OP_A,
  input  logic [DATA_WIDTH-1:0] OP_B,
  input  logic                  MTHI,
  input  logic                  MTLO,
  input  logic [DATA_WIDTH-1:0] WDATA,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [DATA_WIDTH-1:0] HI,
  output logic [DATA_WIDTH-1:0] LO
);

  localparam logic [CNT_WIDTH-1:0] CNT_INIT = latency_preload(LATENCY);

  state_t                state;
  logic [CNT_WIDTH-1:0]  cnt;
  logic [DATA_WIDTH-1:0] op_a_q;
  logic [DATA_WIDTH-1:0] op_b_q;
  logic                  signed_q;
  logic                  done_q;

  logic [PROD_WIDTH-1:0] prod_signed;
  logic [PROD_WIDTH-1:0] prod_unsigned;
  logic [PROD_WIDTH-1:0] prod_sel;

  logic                  load_prod;
  logic                  we_hi;
  logic                  we_lo;

  // Only the latched operands feed the arrays, so OP_A/OP_B may change freely
  // once a multiply has been accepted.
  MULT32 u_mult_s (
    .a (op_a_q),
    .b (op_b_q),
    .p (prod_signed)
  );

  MULT32_U u_mult_u (
    .a (op_a_q),
    .b (op_b_q),
    .p (prod_unsigned)
  );

  assign prod_sel = signed_q ? prod_signed : prod_unsigned;

  // Controller FSM: accept a START from IDLE, count down the hold window in
  // BUSY, and pulse DONE on the edge that loads HI/LO.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      signed_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (START) begin
            op_a_q   <= OP_A;
            op_b_q   <= OP_B;
            signed_q <= SIGNED_OP;
            cnt      <= CNT_INIT;
            state    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            done_q <= 1'b1;
            state  <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // HI/LO write strobes: the product lands on the last BUSY edge; direct
  // writes are honoured only in IDLE and are dropped when START is present.
  assign load_prod = (state == ST_BUSY) && (cnt == '0);
  assign we_hi     = (state == ST_IDLE) && !START && MTHI;
  assign we_lo     = (state == ST_IDLE) && !START && MTLO;

  hilo_reg_pair u_hilo (
    .clk       (CLK),
    .rst       (RST),
    .load_prod (load_prod),
    .product   (prod_sel),
    .we_hi     (we_hi),
    .we_lo     (we_lo),
    .wdata     (WDATA),
    .hi        (HI),
    .lo        (LO)
  );

  assign BUSY = (state == ST_BUSY);
  assign DONE = done_q;

endmodule

// File: tb/tb_mult_hilo_ctrl.sv
// Self-checking bench for mult_hilo_ctrl: directed corner cases followed by
// randomized traffic, all compared against a cycle-indexed reference model.
module tb_mult_hilo_ctrl;

  localparam int LAT = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic        START;
  logic        SIGNED_OP;
  logic [31:0] OP_A;
  logic [31:0] OP_B;
  logic        MTHI;
  logic        MTLO;
  logic [31:0] WDATA;
  logic        BUSY;
  logic        DONE;
  logic [31:0] HI;
  logic [31:0] LO;

  int checkCount = 0;
  int passCount  = 0;

  // Reference model state: the cycle index at which the pending product lands.
  int          cyc     = 0;
  bit          mBusy   = 1'b0;
  bit          mDone   = 1'b0;
  int          mFinish = 0;
  logic [63:0] mProd   = '0;
  logic [31:0] mHi     = '0;
  logic [31:0] mLo     = '0;

  always #5 CLK = ~CLK;

  mult_hilo_ctrl #(.LATENCY(LAT)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .START     (START),
    .SIGNED_OP (SIGNED_OP),
    .OP_A      (OP_A),
    .OP_B      (OP_B),
    .MTHI      (MTHI),
    .MTLO      (MTLO),
    .WDATA     (WDATA),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .HI        (HI),
    .LO        (LO)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  // Full-width product straight from integer arithmetic.
  function automatic logic [63:0] refProduct(input bit sgn, input logic [31:0] a,
                                             input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    ua = {32'b0, a};
    ub = {32'b0, b};
    return ua * ub;
  endfunction

  // Advance the model by one rising edge using the inputs as sampled there.
  task automatic modelEdge();
    cyc++;
    mDone = 1'b0;
    if (mBusy) begin
      if (cyc == mFinish) begin
        {mHi, mLo} = mProd;
        mDone      = 1'b1;
        mBusy      = 1'b0;
      end
    end else if (START) begin
      mBusy   = 1'b1;
      mFinish = cyc + LAT;
      mProd   = refProduct(SIGNED_OP, OP_A, OP_B);
    end else begin
      if (MTHI) mHi = WDATA;
      if (MTLO) mLo = WDATA;
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, "/busy"}, {63'b0, BUSY}, {63'b0, mBusy});
    checkOutput({tag, "/done"}, {63'b0, DONE}, {63'b0, mDone});
    checkOutput({tag, "/hi"}, {32'b0, HI}, {32'b0, mHi});
    checkOutput({tag, "/lo"}, {32'b0, LO}, {32'b0, mLo});
  endtask

  task automatic applyStimulus(input string tag, input bit start, input bit sgn,
                               input logic [31:0] a, input logic [31:0] b,
                               input bit mthi, input bit mtlo, input logic [31:0] wd);
    @(negedge CLK);
    START     = start;
    SIGNED_OP = sgn;
    OP_A      = a;
    OP_B      = b;
    MTHI      = mthi;
    MTLO      = mtlo;
    WDATA     = wd;
    @(posedge CLK);
    modelEdge();
    #1;
    checkAll(tag);
  endtask

  // Idle cycle with scrambled operand/data inputs and no requests.
  task automatic idleCycles(input string tag, input int n);
    for (int i = 0; i < n; i++)
      applyStimulus(tag, 1'b0, 1'($urandom), $urandom, $urandom, 1'b0, 1'b0, $urandom);
  endtask

  task automatic resetModel();
    mBusy = 1'b0;
    mDone = 1'b0;
    mHi   = '0;
    mLo   = '0;
  endtask

  initial begin
    RST = 1'b1; START = 1'b0; SIGNED_OP = 1'b0; OP_A = '0; OP_B = '0;
    MTHI = 1'b0; MTLO = 1'b0; WDATA = '0;

    // Reset held across edges, with requests present that must be ignored.
    repeat (2) @(posedge CLK);
    START = 1'b1; MTHI = 1'b1; MTLO = 1'b1; WDATA = 32'hFFFF_FFFF;
    @(posedge CLK);
    #1;
    checkAll("reset");
    @(negedge CLK);
    RST = 1'b0; START = 1'b0; MTHI = 1'b0; MTLO = 1'b0;
    idleCycles("idle", 2);

    // Signed -3 * 5, operands scrambled every cycle after acceptance.
    applyStimulus("sgnNeg", 1'b1, 1'b1, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0, 32'd0);
    idleCycles("sgnNeg", LAT);
    checkOutput("sgnNeg_done", {63'b0, DONE}, 64'd1);
    checkOutput("sgnNeg_hi", {32'b0, HI}, 64'hFFFF_FFFF);
    checkOutput("sgnNeg_lo", {32'b0, LO}, 64'hFFFF_FFF1);
    idleCycles("post", 1);

    // Unsigned max * max.
    applyStimulus("uMax", 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0);
    idleCycles("uMax", LAT);
    checkOutput("uMax_hi", {32'b0, HI}, 64'hFFFF_FFFE);
    checkOutput("uMax_lo", {32'b0, LO}, 64'h0000_0001);

    // Signed most-negative squared.
    applyStimulus("sMin", 1'b1, 1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'd0);
    idleCycles("sMin", LAT);
    checkOutput("sMin_hi", {32'b0, HI}, 64'h4000_0000);
    checkOutput("sMin_lo", {32'b0, LO}, 64'h0);

    // START + MTHI while busy are dropped; START in the DONE cycle is taken.
    applyStimulus("busyIgn", 1'b1, 1'b0, 32'd7, 32'd6, 1'b0, 1'b0, 32'd0);
    applyStimulus("busyIgn", 1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 1'b1, 1'b0, 32'hAAAA_5555);
    idleCycles("busyIgn", LAT - 1);
    checkOutput("busyIgn_hi", {32'b0, HI}, 64'd0);
    checkOutput("busyIgn_lo", {32'b0, LO}, 64'd42);
    applyStimulus("doneStart", 1'b1, 1'b1, 32'd2, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0);
    checkOutput("doneStart_busy", {63'b0, BUSY}, 64'd1);
    idleCycles("doneStart", LAT);
    checkOutput("doneStart_lo", {32'b0, LO}, 64'hFFFF_FFFE);

    // Idle direct writes, then MTLO dropped when coincident with START.
    applyStimulus("mtBoth", 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 32'h1234_5678);
    checkOutput("mtBoth_hi", {32'b0, HI}, 64'h1234_5678);
    checkOutput("mtBoth_lo", {32'b0, LO}, 64'h1234_5678);
    applyStimulus("startMtlo", 1'b1, 1'b0, 32'd3, 32'd3, 1'b0, 1'b1, 32'hDEAD_BEEF);
    checkOutput("startMtlo_lo", {32'b0, LO}, 64'h1234_5678);
    idleCycles("startMtlo", LAT);
    checkOutput("startMtlo_hi", {32'b0, HI}, 64'd0);
    checkOutput("startMtlo_fin", {32'b0, LO}, 64'd9);

    // Asynchronous reset in the middle of a multiply.
    applyStimulus("midRst", 1'b1, 1'b0, 32'h0012_3456, 32'h0065_4321, 1'b0, 1'b0, 32'd0);
    idleCycles("midRst", 1);
    @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    resetModel();
    checkAll("midRst_async");
    @(posedge CLK);
    #1;
    checkAll("midRst_held");
    @(negedge CLK);
    RST = 1'b0;
    idleCycles("afterRst", LAT + 2);

    // Randomized traffic with a mix of special and random operands.
    for (int i = 0; i < 600; i++) begin
      logic [31:0] a, b;
      a = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 1) ? 32'h8000_0000 : 32'hFFFF_FFFF)
                                      : $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      applyStimulus("rand", ($urandom_range(0, 9) < 3), 1'($urandom), a, b,
                    ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), $urandom);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/mult_hilo_ctrl.md
Name: mult_hilo_ctrl

Overview:
- Sequential multiply control stage directly downstream of the combinational 32x32 multipliers (MULT32 signed, MULT32_U unsigned).
- Latches operands on a START request and holds them stable for a fixed number of cycles. This gives the combinational array a multi-cycle path.
- At the end of that window it captures the 64-bit product into architectural HI/LO registers.
- Also services direct HI/LO writes (MTHI/MTLO) and reports BUSY to the control unit for stall generation.

Parameters:
- LATENCY, 4, cycles from accepted START edge to HI/LO update; legal range 1..15.
- DATA_WIDTH, 32, operand and HI/LO width; fixed at 32 for this design.

Ports:
- CLK  in  1  system clock, rising-edge.
- RST  in  1  reset, asynchronous, active-high.
- START  in  1  request a multiply; sampled at rising CLK.
- SIGNED_OP  in  1  1 = signed multiply (MULT32), 0 = unsigned (MULT32_U).
- OP_A  in  32  multiplicand.
- OP_B  in  32  multiplier.
- MTHI  in  1  write WDATA into HI.
- MTLO  in  1  write WDATA into LO.
- WDATA  in  32  data for MTHI/MTLO.
- BUSY  out  1  multiply in progress.
- DONE  out  1  one-cycle pulse: HI/LO just updated by a multiply.
- HI  out  32  upper product word / HI register.
- LO  out  32  lower product word / LO register.

Behaviour:
- Reset (RST=1, asynchronous): state=IDLE, counter=0, operand regs=0, HI=0, LO=0, BUSY=0, DONE=0. All are held while RST=1.
- States: IDLE and BUSY. BUSY output = (state==BUSY), registered.
- IDLE and START=1 at edge t:
  - Latch OP_A, OP_B and SIGNED_OP.
  - Load counter = LATENCY-1.
  - Go to BUSY.
  - MTHI/MTLO in the same cycle are ignored (START has priority).
- BUSY, on each edge:
  - If counter != 0: decrement it.
  - If counter == 0: HI/LO <= product selected by the latched SIGNED_OP, DONE <= 1, go to IDLE.
- Latency: HI/LO hold the new product and DONE=1 after edge t+LATENCY. LATENCY=1 gives the update at edge t+1.
- DONE is high for exactly one cycle and 0 at every other time.
- START while BUSY: ignored with no queuing. The requester must hold off until BUSY=0.
- START in the DONE cycle: state is IDLE, so it is accepted. Back-to-back multiplies therefore run every LATENCY+1 cycles.
- Operand inputs may change freely after the accept edge. Only the latched copies feed the multipliers.
- IDLE and no START:
  - MTHI=1 -> HI<=WDATA at the edge.
  - MTLO=1 -> LO<=WDATA at the edge.
  - Both high -> both are written with WDATA.
- MTHI/MTLO while BUSY: ignored. HI/LO keep their old value until the multiply completes.
- HI/LO outputs always reflect the registers. They never show combinational multiplier output.
- RST asserted mid-multiply: the operation is aborted and no DONE pulse occurs. After RST is released the block is IDLE with HI=LO=0.
- Product width: full 64-bit, {HI,LO}. Signed mode gives the two's-complement product; no overflow condition exists.

Decomposition:
- Shared package/definitions file:
  - State encoding (IDLE=1'b0, BUSY=1'b1).
  - Default LATENCY.
  - Counter width (4 bits).
  - DATA_WIDTH constant.
- Sub-module hilo_reg_pair: two 32-bit registers with independent write enables, async active-high reset, a 64-bit product-load port and a WDATA port.
- Top level contains:
  - The FSM and counter.
  - Operand latches.
  - One MULT32 and one MULT32_U instance.
  - A 64-bit 2:1 product select.

Test Plan:
- Reset then idle: HI=LO=0, BUSY=0, DONE=0. Asserting RST mid-operation returns all outputs to 0 immediately, with no clock edge needed.
- Signed, LATENCY=4: START, SIGNED_OP=1, OP_A=0xFFFFFFFD (-3), OP_B=5 -> BUSY for 4 cycles, DONE pulse, HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- Unsigned: OP_A=OP_B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. Signed OP_A=OP_B=0x80000000 -> HI=0x40000000, LO=0.
- START while BUSY with different operands plus MTHI=1 -> both ignored; the first product is stored unchanged. A START in the DONE cycle is accepted (BUSY=1 next cycle).
- Idle MTHI+MTLO with WDATA=0x12345678 -> HI=LO=0x12345678. START+MTLO in the same cycle -> MTLO dropped and LO gets the product.
- Operands changed every cycle after the accept edge -> the result matches the values latched at the accept edge.
